// File: rtl/tlc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlc_pkg
// Description : Shared lamp codes, FSM state encoding, register map offsets
//               and lamp decode helper for the multi-approach traffic light.
// Revision    : 1.0 - initial release
// ============================================================================
package tlc_pkg;

  // Lamp codes driven per approach
  localparam logic [1:0] LAMP_RED    = 2'd0;
  localparam logic [1:0] LAMP_YELLOW = 2'd1;
  localparam logic [1:0] LAMP_GREEN  = 2'd2;
  localparam logic [1:0] LAMP_OFF    = 2'd3;

  // Controller phases
  typedef enum logic [1:0] {
    S_ALLRED = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_FLASH  = 2'd3
  } fsm_e;

  // Register addresses above the per-approach green block, relative to NUM_DIR
  localparam int ADDR_YELLOW_OFS = 0;
  localparam int ADDR_ALLRED_OFS = 1;
  localparam int ADDR_MODE_OFS   = 2;

  // Lamp shown by one approach given the phase, whether it owns the phase,
  // and the current half of the flash cycle.
  function automatic logic [1:0] lamp_code(input fsm_e st, input logic owner,
                                           input logic flash_off);
    logic [1:0] code;
    code = LAMP_RED;
    case (st)
      S_GREEN:  if (owner) code = LAMP_GREEN;
      S_YELLOW: if (owner) code = LAMP_YELLOW;
      S_FLASH:  code = flash_off ? LAMP_OFF : LAMP_RED;
      default:  code = LAMP_RED;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tlc_sec_timer.sv
`default_nettype none
// ============================================================================
// Module      : tlc_sec_timer
// Description : Clock prescaler plus loadable seconds down-counter. done_o is
//               high on the last cycle of a duration of dur_i seconds.
// Revision    : 1.0 - initial release
// ============================================================================
module tlc_sec_timer
  import tlc_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1000,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] dur_i,
  output logic                  done_o
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0]         presc_q;
  logic [DATA_WIDTH-1:0] secs_q;
  logic                  w_wrap;

  assign w_wrap = (presc_q == PRESC_MAX);
  // Counter holds remaining whole seconds minus one, so done lands exactly
  // dur_i * TICKS_PER_SEC cycles after the load.
  assign done_o = w_wrap && (secs_q == '0);

  // Prescaler and seconds counter; a load restarts both. Callers never load 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      secs_q  <= '0;
    end else if (load_i) begin
      presc_q <= '0;
      secs_q  <= dur_i - DATA_WIDTH'(1);
    end else if (w_wrap) begin
      presc_q <= '0;
      if (secs_q != '0) secs_q <= secs_q - DATA_WIDTH'(1);
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/tlc_multi.sv
`default_nettype none
// ============================================================================
// Module      : tlc_multi
// Description : Round-robin traffic light controller for NUM_DIR approaches
//               with run-time programmable durations, zero-green skip,
//               all-red clearance and flashing-red mode.
// Revision    : 1.0 - initial release
// ============================================================================
module tlc_multi
  import tlc_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1000,
  parameter int NUM_DIR       = 4,
  parameter int ADDR_WIDTH    = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int DEF_GREEN     = 5,
  parameter int DEF_YELLOW    = 2,
  parameter int DEF_ALLRED    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic [DATA_WIDTH-1:0]      data,
  input  logic                       valid,
  output logic                       ready,
  output logic [2*NUM_DIR-1:0]       state,
  output logic [$clog2(NUM_DIR)-1:0] cur_dir,
  output logic                       phase_start
);

  localparam int DW = $clog2(NUM_DIR);
  localparam logic [ADDR_WIDTH-1:0] A_YELLOW = ADDR_WIDTH'(NUM_DIR + ADDR_YELLOW_OFS);
  localparam logic [ADDR_WIDTH-1:0] A_ALLRED = ADDR_WIDTH'(NUM_DIR + ADDR_ALLRED_OFS);
  localparam logic [ADDR_WIDTH-1:0] A_MODE   = ADDR_WIDTH'(NUM_DIR + ADDR_MODE_OFS);
  localparam logic [DATA_WIDTH-1:0] ONE_SEC  = DATA_WIDTH'(1);

  // Shadow configuration registers
  logic [DATA_WIDTH-1:0] green_q [NUM_DIR];
  logic [DATA_WIDTH-1:0] yellow_q;
  logic [DATA_WIDTH-1:0] allred_q;
  logic                  flash_q;
  logic                  ready_q;
  logic                  w_wr;

  // Controller state
  fsm_e                  fsm_q, fsm_d;
  logic [DW-1:0]         cur_dir_q, dir_d;
  logic                  off_q, off_d;
  logic                  first_q, first_d;
  logic                  pstart_q, pstart_d;
  logic [2*NUM_DIR-1:0]  state_q, state_d;

  // Timer interface and next-approach search
  logic                  w_done;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_dur;
  logic [DATA_WIDTH-1:0] w_yellow_dur;
  logic [DATA_WIDTH-1:0] w_allred_dur;
  logic [DW-1:0]         w_start;
  logic [DW-1:0]         w_sel;
  logic                  w_found;

  assign w_wr         = valid && ready_q;
  assign w_yellow_dur = (yellow_q == '0) ? ONE_SEC : yellow_q;
  assign w_allred_dur = (allred_q == '0) ? ONE_SEC : allred_q;

  assign ready       = ready_q;
  assign state       = state_q;
  assign cur_dir     = cur_dir_q;
  assign phase_start = pstart_q;

  // Register file: writes land on the accepting edge; unmapped addresses are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIR; i++) green_q[i] <= DATA_WIDTH'(DEF_GREEN);
      yellow_q <= DATA_WIDTH'(DEF_YELLOW);
      allred_q <= DATA_WIDTH'(DEF_ALLRED);
      flash_q  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (w_wr) begin
        for (int i = 0; i < NUM_DIR; i++) begin
          if (addr == ADDR_WIDTH'(i)) green_q[i] <= data;
        end
        if (addr == A_YELLOW) yellow_q <= data;
        if (addr == A_ALLRED) allred_q <= data;
        if (addr == A_MODE)   flash_q  <= data[0];
      end
    end
  end

  // Find the first approach with a nonzero green, cyclically from w_start
  always_comb begin
    w_start = '0;
    if (!first_q && (cur_dir_q != DW'(NUM_DIR - 1))) w_start = cur_dir_q + DW'(1);
    w_found = 1'b0;
    w_sel   = '0;
    // Descending search distance so the nearest candidate is assigned last
    for (int k = NUM_DIR - 1; k >= 0; k--) begin
      for (int i = 0; i < NUM_DIR; i++) begin
        if (((int'(w_start) + k) % NUM_DIR == i) && (green_q[i] != '0)) begin
          w_found = 1'b1;
          w_sel   = DW'(i);
        end
      end
    end
  end

  // Next phase selection; every transition coincides with a timer expiry
  always_comb begin
    fsm_d    = fsm_q;
    dir_d    = cur_dir_q;
    off_d    = off_q;
    first_d  = first_q;
    pstart_d = 1'b0;
    w_load   = 1'b0;
    w_dur    = ONE_SEC;
    if (w_done) begin
      w_load   = 1'b1;
      pstart_d = 1'b1;
      case (fsm_q)
        S_GREEN: begin
          // A running green always finishes through yellow, even in flash mode
          fsm_d = S_YELLOW;
          w_dur = w_yellow_dur;
        end
        S_YELLOW: begin
          if (flash_q) begin
            fsm_d = S_FLASH;
            off_d = 1'b0;
          end else begin
            fsm_d = S_ALLRED;
            w_dur = w_allred_dur;
          end
        end
        S_ALLRED: begin
          if (flash_q) begin
            fsm_d = S_FLASH;
            off_d = 1'b0;
          end else if (w_found) begin
            fsm_d   = S_GREEN;
            dir_d   = w_sel;
            first_d = 1'b0;
            w_dur   = green_q[w_sel];
          end else begin
            fsm_d = S_ALLRED;
            w_dur = w_allred_dur;
          end
        end
        S_FLASH: begin
          if (!flash_q) begin
            fsm_d = S_ALLRED;
            off_d = 1'b0;
            w_dur = w_allred_dur;
          end else begin
            // Toggle within flash mode is not a new phase
            off_d    = ~off_q;
            pstart_d = 1'b0;
          end
        end
        default: begin
          fsm_d = S_ALLRED;
          w_dur = w_allred_dur;
        end
      endcase
    end
  end

  // Lamp outputs decoded from the next state so they register with it
  always_comb begin
    state_d = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      state_d[2*i +: 2] = lamp_code(fsm_d, dir_d == DW'(i), off_d);
    end
  end

  // Controller state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q     <= S_ALLRED;
      cur_dir_q <= '0;
      off_q     <= 1'b0;
      first_q   <= 1'b1;
      pstart_q  <= 1'b0;
      state_q   <= {NUM_DIR{LAMP_RED}};
    end else begin
      fsm_q     <= fsm_d;
      cur_dir_q <= dir_d;
      off_q     <= off_d;
      first_q   <= first_d;
      pstart_q  <= pstart_d;
      state_q   <= state_d;
    end
  end

  tlc_sec_timer #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (w_load),
    .dur_i  (w_dur),
    .done_o (w_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_tlc_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlc_multi
// Description : Directed self-checking bench for tlc_multi (TICKS_PER_SEC=10,
//               NUM_DIR=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlc_multi;

  localparam int T  = 10;
  localparam int N  = 4;
  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] data  = '0;
  logic          valid = 1'b0;
  logic          ready;
  logic [2*N-1:0] state;
  logic [1:0]    cur_dir;
  logic          phase_start;

  int checks   = 0;
  int failures = 0;
  bit seen_g1  = 1'b0;

  tlc_multi #(
    .TICKS_PER_SEC (T),
    .NUM_DIR       (N),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .DEF_GREEN     (5),
    .DEF_YELLOW    (2),
    .DEF_ALLRED    (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .state       (state),
    .cur_dir     (cur_dir),
    .phase_start (phase_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycles until the next phase_start pulse, sampled on falling edges
  task automatic next_phase(output int len);
    len = 0;
    do begin
      @(negedge clk);
      len++;
    end while (phase_start !== 1'b1 && len < 3000);
    if (phase_start !== 1'b1) begin
      checks++;
      failures++;
      $error("FAIL phase_timeout: observed=no_pulse expected=pulse within %0d cycles", len);
    end
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr  = a;
    data  = d;
    valid = 1'b1;
    check("ready_on_write", {31'd0, ready}, 32'd1);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic skip_to_state(input logic [7:0] pat);
    int len;
    int n;
    n = 0;
    do begin
      next_phase(len);
      n++;
    end while (state !== pat && n < 20);
    check("skip_to_state", {24'd0, state}, {24'd0, pat});
  endtask

  // Default-configuration opening sequence after reset release
  task automatic run_default(input string p);
    int len;
    next_phase(len);
    check({p, "_allred0_len"}, len, 10);
    check({p, "_green0_state"}, {24'd0, state}, 32'h02);
    check({p, "_green0_dir"}, {30'd0, cur_dir}, 0);
    next_phase(len);
    check({p, "_green0_len"}, len, 50);
    check({p, "_yellow0_state"}, {24'd0, state}, 32'h01);
    next_phase(len);
    check({p, "_yellow0_len"}, len, 20);
    check({p, "_allred_state"}, {24'd0, state}, 32'h00);
    next_phase(len);
    check({p, "_allred_len"}, len, 10);
    check({p, "_green1_state"}, {24'd0, state}, 32'h08);
    check({p, "_green1_dir"}, {30'd0, cur_dir}, 1);
  endtask

  // Safety: a GREEN lamp only ever coexists with RED lamps
  always @(negedge clk) begin : mon
    int ng;
    int nnr;
    ng  = 0;
    nnr = 0;
    for (int i = 0; i < N; i++) begin
      if (state[2*i +: 2] == 2'd2) ng++;
      if (state[2*i +: 2] != 2'd0) nnr++;
    end
    if (state[3:2] == 2'd2) seen_g1 = 1'b1;
    checks++;
    assert ((ng == 0 || nnr == 1) === 1'b1) else begin
      failures++;
      $error("FAIL green_exclusive: observed state=%h expected=single green among reds", state);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int len;
    int total;
    int n;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_state", {24'd0, state}, 0);
    check("rst_dir", {30'd0, cur_dir}, 0);
    check("rst_pstart", {31'd0, phase_start}, 0);
    check("rst_ready", {31'd0, ready}, 0);
    rst = 1'b0;

    // 1: default sequence and full rotation length
    run_default("s1");
    total = 80;
    n = 0;
    do begin
      next_phase(len);
      total += len;
      n++;
    end while (state !== 8'h02 && n < 20);
    check("s1_cycle_len", total, 320);

    // 2: GREEN={3,0,4,2}, YELLOW=1, ALLRED=2, back-to-back during green0
    write_reg(3'd0, 8'd3);
    write_reg(3'd1, 8'd0);
    write_reg(3'd2, 8'd4);
    write_reg(3'd3, 8'd2);
    write_reg(3'd4, 8'd1);
    write_reg(3'd5, 8'd2);
    seen_g1 = 1'b0;
    next_phase(len);
    check("s2_yellow0_state", {24'd0, state}, 32'h01);
    next_phase(len);
    check("s2_yellow_len", len, 10);
    next_phase(len);
    check("s2_allred_len", len, 20);
    check("s2_dir_a", {30'd0, cur_dir}, 2);
    next_phase(len);
    check("s2_green2_len", len, 40);
    next_phase(len);
    next_phase(len);
    check("s2_dir_b", {30'd0, cur_dir}, 3);
    next_phase(len);
    check("s2_green3_len", len, 20);
    next_phase(len);
    next_phase(len);
    check("s2_dir_c", {30'd0, cur_dir}, 0);
    next_phase(len);
    check("s2_green0_len", len, 30);

    // 3: shadow write mid-green does not affect the running phase
    skip_to_state(8'h02);
    repeat (15) @(negedge clk);
    write_reg(3'd0, 8'd9);
    next_phase(len);
    check("s3_cur_green_len", len + 16, 30);
    skip_to_state(8'h02);
    next_phase(len);
    check("s3_new_green_len", len, 90);
    check("s2_no_green1", {31'd0, seen_g1}, 0);

    // 4: flash mode requested during green2
    skip_to_state(8'h20);
    write_reg(3'd6, 8'd1);
    next_phase(len);
    check("s4_green2_len", len + 1, 40);
    check("s4_yellow2_state", {24'd0, state}, 32'h10);
    next_phase(len);
    check("s4_yellow_len", len, 10);
    check("s4_flash_red", {24'd0, state}, 32'h00);
    repeat (9) @(negedge clk);
    check("s4_flash_red_hold", {24'd0, state}, 32'h00);
    @(negedge clk);
    check("s4_flash_off", {24'd0, state}, 32'hFF);
    check("s4_no_pulse_toggle", {31'd0, phase_start}, 0);
    repeat (10) @(negedge clk);
    check("s4_flash_red2", {24'd0, state}, 32'h00);
    write_reg(3'd6, 8'd0);
    next_phase(len);
    check("s4_exit_at_wrap", len, 9);
    check("s4_exit_allred", {24'd0, state}, 32'h00);
    check("s4_exit_dir", {30'd0, cur_dir}, 2);
    next_phase(len);
    check("s4_allred_len", len, 20);
    check("s4_resume_state", {24'd0, state}, 32'h80);
    check("s4_resume_dir", {30'd0, cur_dir}, 3);

    // 5: all greens zero -> repeated all-red, then enable approach 2
    write_reg(3'd0, 8'd0);
    write_reg(3'd1, 8'd0);
    write_reg(3'd2, 8'd0);
    write_reg(3'd3, 8'd0);
    next_phase(len);
    next_phase(len);
    next_phase(len);
    check("s5_reload_len_a", len, 20);
    check("s5_reload_state", {24'd0, state}, 32'h00);
    next_phase(len);
    check("s5_reload_len_b", len, 20);
    write_reg(3'd2, 8'd1);
    next_phase(len);
    check("s5_allred_len", len + 1, 20);
    check("s5_green2_state", {24'd0, state}, 32'h20);
    check("s5_green2_dir", {30'd0, cur_dir}, 2);
    next_phase(len);
    check("s5_green2_len", len, 10);
    check("s5_no_green1", {31'd0, seen_g1}, 0);

    // 6: asynchronous reset mid-yellow, then default replay
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("s6_async_state", {24'd0, state}, 0);
    check("s6_async_ready", {31'd0, ready}, 0);
    check("s6_async_dir", {30'd0, cur_dir}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_default("s6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tlc_multi.md
Name: tlc_multi

Overview:
Parametrised successor of the single-approach traffic light controller. Sequences NUM_DIR approaches round-robin: GREEN -> YELLOW -> ALL_RED clearance -> next approach. Durations are programmed at run time over the existing addr/data/valid/ready register interface. Adds per-approach green times, zero-green skip, a programmable all-red clearance, and a flashing-red fault/night mode. Sits between the configuration master and the lamp drivers.

Parameters:
TICKS_PER_SEC, 1000, clock cycles per second (integer; replaces the real-valued MHz FREQ for synthesis).
NUM_DIR, 4, number of approaches; legal range 2..8.
ADDR_WIDTH, 3, config address width; must satisfy 2**ADDR_WIDTH >= NUM_DIR+3.
DATA_WIDTH, 8, config data width; durations are in seconds.
DEF_GREEN, 5, reset green time for every approach, in seconds.
DEF_YELLOW, 2, reset yellow time, in seconds.
DEF_ALLRED, 1, reset all-red clearance time, in seconds.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
addr  in  ADDR_WIDTH  config register address
data  in  DATA_WIDTH  config write data
valid  in  1  write request
ready  out  1  write accepted when valid && ready
state  out  2*NUM_DIR  lamp code per approach; approach i occupies bits [2i+1:2i]
cur_dir  out  $clog2(NUM_DIR)  index of the approach currently owning the phase
phase_start  out  1  one-cycle pulse on the first cycle of each phase

Behaviour:
- Lamp codes: RED=0, YELLOW=1, GREEN=2, OFF=3.
- Register map: addresses 0..NUM_DIR-1 hold GREEN[i]; NUM_DIR holds YELLOW; NUM_DIR+1 holds ALLRED; NUM_DIR+2 holds MODE, where bit0 = flash. Writes to other addresses are accepted and discarded.
- Reset values: state = all RED; cur_dir = 0; phase_start = 0; ready = 0; shadow registers = DEF_* values; MODE = 0; FSM = S_ALLRED; timer cleared.
- Handshake:
  - ready = 1 on every cycle after reset is released (first posedge with rst low).
  - A write lands in the shadow register on the accepting edge.
  - Back-to-back writes on consecutive cycles are legal.
- Shadow/active split: a phase duration is sampled from the shadow register only when that phase is loaded. Writes never alter a phase already in progress.
- Timer:
  - Prescaler counts 0..TICKS_PER_SEC-1.
  - A seconds down-counter is loaded with the duration on the phase_start cycle and decrements on each prescaler wrap.
  - The phase ends on the cycle after the counter reaches 0 at a wrap, so phase length is exactly N*TICKS_PER_SEC cycles.
  - YELLOW = 0 and ALLRED = 0 are treated as 1.
- FSM states:
  - S_ALLRED: all RED for ALLRED seconds, then advance to the next approach j (cyclic from cur_dir+1; after reset, starting at approach 0) with GREEN[j] != 0, and go to S_GREEN. If every GREEN[i] == 0, reload S_ALLRED.
  - S_GREEN: approach cur_dir shows GREEN, all others RED, for GREEN[cur_dir] seconds, then S_YELLOW.
  - S_YELLOW: approach cur_dir shows YELLOW, all others RED, for YELLOW seconds, then S_ALLRED.
  - S_FLASH: all approaches toggle RED/OFF every second, starting RED.
- Flash entry: when MODE.flash = 1 is observed at any phase boundary, the next state is S_FLASH instead of the normal successor. An in-progress green always completes its yellow and all-red first: a GREEN phase ending goes to S_YELLOW, and S_FLASH is entered only at the end of YELLOW or ALLRED.
- Flash exit: when MODE.flash = 0, exit at the next 1-second wrap into S_ALLRED, keeping cur_dir, so service resumes with the next nonzero approach.
- phase_start pulses on every FSM state load, including an S_ALLRED reload. It does not pulse on flash toggles.
- Asynchronous rst mid-phase: all outputs return to reset values immediately, and shadow registers revert to DEF_* values.
- A green approach never coexists with any non-RED approach, except during S_FLASH where there is no GREEN at all. The bench checks this as an assertion.

Decomposition:
- Package tlc_pkg holds the lamp code constants, the FSM state encoding (S_ALLRED, S_GREEN, S_YELLOW, S_FLASH), and address offset constants expressed relative to NUM_DIR (ADDR_YELLOW_OFS = 0, ADDR_ALLRED_OFS = 1, ADDR_MODE_OFS = 2).
- One sub-module, tlc_sec_timer: prescaler plus loadable seconds down-counter, with load/duration inputs and a done/tick output.

Test Plan:
1. Defaults, TICKS_PER_SEC=10, NUM_DIR=4, no writes -> after reset, ALLRED for 10 cycles, then approach 0 GREEN for 50 cycles and YELLOW for 20 cycles, then ALLRED for 10, then approach 1 GREEN. Full cycle length = 4*80 = 320 cycles.
2. Program GREEN = {3,0,4,2}, YELLOW=1, ALLRED=2 with back-to-back writes -> approach 1 is never GREEN; cur_dir sequence is 0,2,3,0; approach 0 GREEN lasts exactly 30 cycles.
3. Write GREEN[0]=9 mid-way through approach 0's green -> the current green keeps its old length; the next approach 0 green lasts 90 cycles.
4. Set MODE=1 during a green -> that green completes, then YELLOW, then S_FLASH with all approaches toggling RED/OFF every 10 cycles. Clear MODE -> ALLRED, then the next nonzero approach.
5. All GREEN = 0 -> permanent all RED with phase_start pulsing every ALLRED*10 cycles. Then write GREEN[2]=1 -> approach 2 goes GREEN after the current ALLRED phase ends.
6. Assert rst asynchronously between clock edges mid-yellow -> state goes all RED and ready goes 0 immediately. After release, the default sequence of scenario 1 replays exactly.
